// File: rtl/can_timing_pkg.sv
// Segment encodings, sync direction and width constants shared by the CAN bit timing
// and synchronization blocks.
package can_timing_pkg;

    localparam int TQ_W  = 5;
    localparam int SEG_W = 4;

    typedef enum logic [1:0] {
        SEG_SYNC   = 2'b00,
        SEG_PROP   = 2'b01,
        SEG_PHASE1 = 2'b10,
        SEG_PHASE2 = 2'b11
    } seg_e;

    typedef enum logic {
        SYNC_LATE  = 1'b0,
        SYNC_EARLY = 1'b1
    } sync_dir_e;

    // Clamp a tq-wide phase error to the largest value a segment-wide field can carry.
    function automatic logic [SEG_W-1:0] sat_tq(input logic [TQ_W-1:0] v);
        return (|(v >> SEG_W)) ? {SEG_W{1'b1}} : v[SEG_W-1:0];
    endfunction

endpackage

// File: rtl/can_sync_controller_if.sv
// Signal bundle between the protocol/bit timing side (master) and the sync controller (slave).
// Carries raw RX, sync permissions, timing position inputs and the sync control outputs.
interface can_sync_controller_if;

    logic                                enable;
    logic                                rx_raw;
    logic                                hard_sync_enable;
    logic                                resync_enable;
    logic [can_timing_pkg::SEG_W-1:0]    sjw;
    can_timing_pkg::seg_e                current_segment;
    logic [can_timing_pkg::TQ_W-1:0]     quanta_counter;
    logic [can_timing_pkg::TQ_W-1:0]     bit_position;
    logic [can_timing_pkg::SEG_W-1:0]    phase_seg2;
    logic                                sample_point;
    logic                                bit_timing_end;

    logic                                rx_sync;
    logic                                edge_detected;
    logic                                apply_hard_sync;
    logic                                apply_resync;
    logic [can_timing_pkg::SEG_W-1:0]    sync_adjustment;
    logic                                sync_direction;
    logic                                sampled_bit;

    modport master (
        output enable, rx_raw, hard_sync_enable, resync_enable, sjw, current_segment,
               quanta_counter, bit_position, phase_seg2, sample_point, bit_timing_end,
        input  rx_sync, edge_detected, apply_hard_sync, apply_resync, sync_adjustment,
               sync_direction, sampled_bit
    );

    modport slave (
        input  enable, rx_raw, hard_sync_enable, resync_enable, sjw, current_segment,
               quanta_counter, bit_position, phase_seg2, sample_point, bit_timing_end,
        output rx_sync, edge_detected, apply_hard_sync, apply_resync, sync_adjustment,
               sync_direction, sampled_bit
    );

endinterface

// File: rtl/can_rx_synchronizer.sv
// Purpose: metastability flops on CAN RX, optional glitch filter (CAN_SYNC_GLITCH_FILTER_EN).
// Latency: SYNC_STAGES clocks, plus FILTER_CLKS-1 when the filter is built in.
// Backpressure: none, free-running sampler; resets to recessive.
module can_rx_synchronizer #(
    parameter int SYNC_STAGES = 2
`ifdef CAN_SYNC_GLITCH_FILTER_EN
    , parameter int FILTER_CLKS = 3
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic rx_raw,
    output logic rx_sync
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], rx_raw};
        end
    end

`ifdef CAN_SYNC_GLITCH_FILTER_EN
    localparam int FW = (FILTER_CLKS < 2) ? 2 : FILTER_CLKS;

    // Window = last FW values of the synchronized input; output follows only a unanimous window.
    logic [FW-2:0] hist_q;
    logic [FW-1:0] window;
    logic          held_q;

    assign window  = {hist_q, sync_q[STAGES-1]};
    assign rx_sync = (&window) ? 1'b1 : ((~|window) ? 1'b0 : held_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= '1;
            held_q <= 1'b1;
        end else begin
            hist_q <= window[FW-2:0];
            held_q <= rx_sync;
        end
    end
`else
    assign rx_sync = sync_q[STAGES-1];
`endif

endmodule

// File: rtl/can_sync_controller.sv
// Purpose: CAN edge detect, phase error, hard-sync/resync control, sample latch (filter: CAN_SYNC_GLITCH_FILTER_EN).
// Latency: rx_raw fall -> edge_detected/apply_hard_sync = SYNC_STAGES+1 clocks (+FILTER_CLKS-1 filtered).
// Backpressure: none; one sync per bit enforced by a lock cleared on bit_timing_end.
module can_sync_controller
    import can_timing_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef CAN_SYNC_GLITCH_FILTER_EN
    , parameter int FILTER_CLKS = 3
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    can_sync_controller_if.slave bus
);

    logic             rx_sync;
    logic             rx_prev;
    logic             sync_lock;
    logic             raw_edge;
    logic             lock_eff;
    logic [TQ_W-1:0]  phase_err;
    logic [SEG_W-1:0] err_sat;
    logic [SEG_W-1:0] sjw_eff;
    logic [SEG_W-1:0] adj_next;
    sync_dir_e        dir_next;

    logic             edge_q;
    logic             hard_q;
    logic             resync_q;
    logic [SEG_W-1:0] adj_q;
    logic             dir_q;
    logic             sampled_q;

    can_rx_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef CAN_SYNC_GLITCH_FILTER_EN
        , .FILTER_CLKS (FILTER_CLKS)
`endif
    ) u_rx_sync (
        .clock   (clock),
        .reset   (reset),
        .rx_raw  (bus.rx_raw),
        .rx_sync (rx_sync)
    );

    always_comb begin
        raw_edge  = rx_prev & ~rx_sync & bus.enable;
        // bit_timing_end releases the lock in the same clock an edge may arrive
        lock_eff  = sync_lock & ~bus.bit_timing_end;
        phase_err = '0;
        dir_next  = SYNC_LATE;
        case (bus.current_segment)
            SEG_PROP, SEG_PHASE1: phase_err = bus.bit_position;
            SEG_PHASE2: begin
                phase_err = {1'b0, bus.phase_seg2} - bus.quanta_counter;
                dir_next  = SYNC_EARLY;
            end
            default: phase_err = '0;
        endcase
        sjw_eff  = (bus.sjw == '0) ? SEG_W'(1) : bus.sjw;
        err_sat  = sat_tq(phase_err);
        adj_next = (err_sat < sjw_eff) ? err_sat : sjw_eff;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !bus.enable) begin
            sync_lock <= 1'b0;
            edge_q    <= 1'b0;
            hard_q    <= 1'b0;
            resync_q  <= 1'b0;
            adj_q     <= '0;
            dir_q     <= 1'b0;
            sampled_q <= 1'b1;
        end else begin
            edge_q <= 1'b0;
            hard_q <= 1'b0;
            if (bus.bit_timing_end) begin
                resync_q  <= 1'b0;
                sync_lock <= 1'b0;
            end
            if (bus.sample_point) begin
                sampled_q <= rx_sync;
            end
            // sampled_q here is still the pre-edge value when sample_point coincides
            if (raw_edge && !lock_eff) begin
                if (bus.hard_sync_enable) begin
                    edge_q    <= 1'b1;
                    hard_q    <= 1'b1;
                    resync_q  <= 1'b0;
                    sync_lock <= 1'b1;
                end else if (bus.resync_enable && sampled_q) begin
                    edge_q    <= 1'b1;
                    sync_lock <= 1'b1;
                    if (phase_err != '0) begin
                        resync_q <= 1'b1;
                        adj_q    <= adj_next;
                        dir_q    <= dir_next;
                    end
                end
            end
        end
    end

    assign bus.rx_sync         = rx_sync;
    assign bus.edge_detected   = edge_q;
    assign bus.apply_hard_sync = hard_q;
    assign bus.apply_resync    = resync_q;
    assign bus.sync_adjustment = adj_q;
    assign bus.sync_direction  = dir_q;
    assign bus.sampled_bit     = sampled_q;

endmodule

// File: tb/tb_can_sync_controller.sv
// Directed and randomized bench for can_sync_controller against an arithmetic reference model.
module tb_can_sync_controller;
    import can_timing_pkg::*;

`ifdef CAN_SYNC_GLITCH_FILTER_EN
    localparam int EDGE_LAT = 5;
`else
    localparam int EDGE_LAT = 3;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    can_sync_controller_if bus();

    can_sync_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    bit m_lock    = 0;
    bit m_apply   = 0;
    int m_adj     = 0;
    bit m_dir     = 0;
    bit m_sampled = 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_lock = 0; m_apply = 0; m_adj = 0; m_dir = 0; m_sampled = 1;
    endtask

    task automatic model_bte();
        m_lock  = 0;
        m_apply = 0;
    endtask

    task automatic model_edge(output bit ed, output bit hs);
        int e;
        int lim;
        ed = 0;
        hs = 0;
        if (!bus.enable || m_lock) return;
        if (bus.hard_sync_enable) begin
            ed = 1; hs = 1; m_lock = 1; m_apply = 0;
        end else if (bus.resync_enable && m_sampled) begin
            ed = 1;
            m_lock = 1;
            if (bus.current_segment == SEG_SYNC) e = 0;
            else if (bus.current_segment == SEG_PHASE2) begin
                e = int'(bus.phase_seg2) - int'(bus.quanta_counter);
                if (e < 0) e += 32;
            end else e = int'(bus.bit_position);
            if (e != 0) begin
                if (e > 15) e = 15;
                lim = (bus.sjw == 0) ? 1 : int'(bus.sjw);
                m_adj   = (e < lim) ? e : lim;
                m_dir   = (bus.current_segment == SEG_PHASE2);
                m_apply = 1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".apply_resync"}, 8'(bus.apply_resync), 8'(m_apply));
        chk({tag, ".adj"},          8'(bus.sync_adjustment), 8'(m_adj));
        chk({tag, ".dir"},          8'(bus.sync_direction), 8'(m_dir));
    endtask

    // Falling edge on rx_raw, checked at the registration clock, then RX returns recessive.
    task automatic do_edge(input string tag, input bit with_bte);
        bit e_ed, e_hs;
        if (with_bte) model_bte();
        model_edge(e_ed, e_hs);
        bus.rx_raw = 1'b0;
        tick(EDGE_LAT - 1);
        chk({tag, ".early"}, 8'(bus.edge_detected), 8'd0);
        if (with_bte) bus.bit_timing_end = 1'b1;
        tick(1);
        bus.bit_timing_end = 1'b0;
        chk({tag, ".edge"}, 8'(bus.edge_detected), 8'(e_ed));
        chk({tag, ".hard"}, 8'(bus.apply_hard_sync), 8'(e_hs));
        check_state(tag);
        tick(1);
        chk({tag, ".edge_pulse"}, 8'(bus.edge_detected | bus.apply_hard_sync), 8'd0);
        chk({tag, ".held"}, 8'(bus.apply_resync), 8'(m_apply));
        bus.rx_raw = 1'b1;
        tick(EDGE_LAT + 1);
    endtask

    task automatic pulse_bte();
        bus.bit_timing_end = 1'b1;
        tick(1);
        bus.bit_timing_end = 1'b0;
        model_bte();
        chk("bte.clear", 8'(bus.apply_resync), 8'd0);
    endtask

    task automatic pulse_sample();
        bus.sample_point = 1'b1;
        tick(1);
        bus.sample_point = 1'b0;
        m_sampled = bus.rx_raw;
        chk("sample", 8'(bus.sampled_bit), 8'(m_sampled));
    endtask

    initial begin
        bit seen;
        bus.enable = 1'b1;           bus.rx_raw = 1'b1;
        bus.hard_sync_enable = 1'b0; bus.resync_enable = 1'b0;
        bus.sjw = 4'd2;              bus.current_segment = SEG_SYNC;
        bus.quanta_counter = '0;     bus.bit_position = '0;
        bus.phase_seg2 = 4'd4;       bus.sample_point = 1'b0;
        bus.bit_timing_end = 1'b0;

        tick(3);
        chk("rst.rx_sync", 8'(bus.rx_sync), 8'd1);
        chk("rst.edge", 8'(bus.edge_detected), 8'd0);
        chk("rst.hard", 8'(bus.apply_hard_sync), 8'd0);
        chk("rst.sampled", 8'(bus.sampled_bit), 8'd1);
        check_state("rst");
        reset = 1'b0;
        tick(EDGE_LAT + 1);

        // hard sync
        bus.hard_sync_enable = 1'b1;
        do_edge("hard_sync", 0);
        bus.hard_sync_enable = 1'b0;
        pulse_bte();

        // late edge in PROP, e=3 clipped to sjw=2, held until bit end
        bus.resync_enable = 1'b1;
        bus.current_segment = SEG_PROP; bus.bit_position = 5'd3;
        do_edge("late_prop", 0);
        tick(4);
        check_state("late_hold");
        pulse_bte();

        // early edge in PHASE2, then sjw=0 cases
        bus.current_segment = SEG_PHASE2; bus.quanta_counter = 5'd3;
        do_edge("early_ph2", 0);
        pulse_bte();
        bus.sjw = 4'd0;
        do_edge("early_sjw0", 0);
        pulse_bte();
        bus.current_segment = SEG_PROP; bus.bit_position = 5'd3;
        do_edge("late_sjw0", 0);
        pulse_bte();
        bus.sjw = 4'd2;

        // SYNC segment edge, then a second edge in the same bit
        bus.current_segment = SEG_SYNC;
        do_edge("sync_seg", 0);
        bus.current_segment = SEG_PROP; bus.bit_position = 5'd5;
        do_edge("second_edge", 0);
        pulse_bte();

        // dominant sampled bit blocks resync
        bus.resync_enable = 1'b0;
        bus.rx_raw = 1'b0;
        tick(EDGE_LAT + 1);
        pulse_sample();
        bus.rx_raw = 1'b1;
        tick(EDGE_LAT + 1);
        bus.resync_enable = 1'b1; bus.bit_position = 5'd4;
        do_edge("sampled_dom", 0);
        pulse_sample();

        // edge coinciding with bit_timing_end while locked
        do_edge("lock_prop", 0);
        bus.current_segment = SEG_PHASE2; bus.quanta_counter = 5'd2;
        do_edge("edge_with_bte", 1);
        tick(3);
        check_state("bte_survive");
        pulse_bte();

        // enable low returns outputs to reset values
        bus.current_segment = SEG_PROP; bus.bit_position = 5'd7;
        do_edge("pre_disable", 0);
        bus.enable = 1'b0;
        tick(1);
        model_clear();
        check_state("disable");
        chk("disable.sampled", 8'(bus.sampled_bit), 8'd1);
        bus.enable = 1'b1;
        tick(1);

        // reset mid-bit clears pending resync
        do_edge("pre_reset", 0);
        reset = 1'b1;
        tick(1);
        model_clear();
        check_state("reset_mid");
        reset = 1'b0;
        tick(EDGE_LAT + 1);

        // 2-clock dominant glitch
        bus.hard_sync_enable = 1'b1;
        bus.rx_raw = 1'b0;
        tick(2);
        bus.rx_raw = 1'b1;
        seen = 1'b0;
        repeat (EDGE_LAT + 4) begin
            tick(1);
            seen |= bus.edge_detected;
        end
`ifdef CAN_SYNC_GLITCH_FILTER_EN
        chk("glitch", 8'(seen), 8'd0);
`else
        chk("glitch", 8'(seen), 8'd1);
`endif
        bus.hard_sync_enable = 1'b0;
        pulse_bte();

        // randomized edges against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) pulse_bte();
            bus.current_segment = seg_e'($urandom_range(0, 3));
            bus.bit_position    = 5'($urandom_range(0, 31));
            bus.phase_seg2      = 4'($urandom_range(1, 15));
            bus.quanta_counter  = 5'($urandom_range(0, int'(bus.phase_seg2)));
            bus.sjw             = 4'($urandom_range(0, 15));
            bus.resync_enable   = ($urandom_range(0, 3) != 0);
            bus.hard_sync_enable = (!m_lock && $urandom_range(0, 4) == 0);
            do_edge("rand", 0);
            bus.hard_sync_enable = 1'b0;
            if ($urandom_range(0, 3) == 0) pulse_sample();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
